id_uop_sequencer: RTL



---
 rtl/id_uop_sequencer.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_uop_sequencer.sv
// id_uop_sequencer: splits block transfers (LDM/STM) into single-register
// LDR/STR uops plus an optional base-writeback ADD/SUB; other instructions
// pass through as one uop. Define ID_SWAP_UOP_EN to also split SWP/SWPB
// into an LDR/STR pair; when it is undefined SWP passes through untouched.
module id_uop_sequencer #(
  parameter int unsigned INSTR_W    = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  output logic               in_ready,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               out_first,
  output logic               out_last,
  output logic               busy
);

  localparam int unsigned LIST_W = 1 << REG_ADDR_W;
  localparam int unsigned CNT_W  = REG_ADDR_W + 1;
  localparam int unsigned OFF_W  = REG_ADDR_W + 5;
  localparam logic [31:0] NOP_UOP = 32'hE1A00000;

  typedef enum logic [1:0] {ST_IDLE, ST_SEQ, ST_WB, ST_SWP2} state_e;

  state_e state_q, state_d;

  logic [LIST_W-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  k_q, k_d, n_q, n_d;
  logic [OFF_W-1:0]  start_q, start_d;
  logic [3:0]        cond_q, cond_d, rn_q, rn_d;
  logic              l_q, l_d, u_q, u_d, w_q, w_d;
`ifdef ID_SWAP_UOP_EN
  logic [3:0]        rm_q, rm_d;
  logic              b_q, b_d;
`endif

  logic               out_valid_q, out_valid_d, out_first_q, out_first_d;
  logic               out_last_q, out_last_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;

  logic              advance, accept;
  logic              in_is_blk, in_is_swp, in_list_nz;
  logic [LIST_W-1:0] in_list, in_rem, seq_rem;
  logic [CNT_W-1:0]  in_cnt;
  logic [OFF_W-1:0]  in_n4, in_start;

  // LDR/STR Rd,[Rn,#off] with the offset sign folded into U
  function automatic logic [31:0] mem_uop(input logic [3:0] cond, input logic l,
                                          input logic b, input logic [3:0] rn,
                                          input logic [3:0] rd,
                                          input logic [OFF_W-1:0] off);
    logic [OFF_W-1:0] mag;
    mag = off[OFF_W-1] ? (-off) : off;
    return {cond, 2'b01, 1'b0, 1'b1, ~off[OFF_W-1], b, 1'b0, l, rn, rd, 12'(mag)};
  endfunction

  // ADD/SUB Rn,Rn,#4n base writeback
  function automatic logic [31:0] wb_uop(input logic [3:0] cond, input logic u,
                                         input logic [3:0] rn,
                                         input logic [CNT_W-1:0] cnt);
    return {cond, 3'b001, (u ? 4'b0100 : 4'b0010), 1'b0, rn, rn, 4'b0000,
            8'({cnt, 2'b00})};
  endfunction

  function automatic logic [REG_ADDR_W-1:0] lowest(input logic [LIST_W-1:0] v);
    lowest = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (v[i]) lowest = REG_ADDR_W'(i);
    end
  endfunction

  function automatic logic [CNT_W-1:0] popcnt(input logic [LIST_W-1:0] v);
    popcnt = '0;
    for (int i = 0; i < LIST_W; i++) begin
      popcnt = popcnt + CNT_W'(v[i]);
    end
  endfunction

  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = (state_q == ST_IDLE) & advance & ~flush;
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q != ST_IDLE);

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;

  // Incoming instruction classification and first-element offset
  always_comb begin
    in_is_blk  = (in_instr[27:25] == 3'b100);
    in_list    = in_instr[LIST_W-1:0];
    in_list_nz = (in_list != '0);
    in_rem     = in_list & (in_list - LIST_W'(1));
    seq_rem    = mask_q & (mask_q - LIST_W'(1));
    in_cnt     = popcnt(in_list);
    in_n4      = OFF_W'({in_cnt, 2'b00});
    case ({in_instr[24], in_instr[23]})
      2'b01:   in_start = '0;
      2'b11:   in_start = OFF_W'(4);
      2'b00:   in_start = OFF_W'(4) - in_n4;
      default: in_start = '0 - in_n4;
    endcase
`ifdef ID_SWAP_UOP_EN
    in_is_swp = (in_instr[27:23] == 5'b00010) & (in_instr[21:20] == 2'b00) &
                (in_instr[7:4] == 4'b1001);
`else
    in_is_swp = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: stay idle for single uops, otherwise walk SEQ/WB/SWP2
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else if (advance) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (in_is_blk && in_list_nz) begin
              if (in_rem != '0)     state_d = ST_SEQ;
              else if (in_instr[21]) state_d = ST_WB;
            end else if (in_is_swp) begin
              state_d = ST_SWP2;
            end
          end
        end
        ST_SEQ:  if (seq_rem == '0) state_d = w_q ? ST_WB : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Uop synthesis and sequence bookkeeping
  always_comb begin
    mask_d      = mask_q;
    k_d         = k_q;
    n_d         = n_q;
    start_d     = start_q;
    cond_d      = cond_q;
    rn_d        = rn_q;
    l_d         = l_q;
    u_d         = u_q;
    w_d         = w_q;
`ifdef ID_SWAP_UOP_EN
    rm_d        = rm_q;
    b_d         = b_q;
`endif
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    if (flush) begin
      out_valid_d = 1'b0;
      mask_d      = '0;
      k_d         = '0;
    end else if (advance) begin
      out_valid_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            out_valid_d = 1'b1;
            out_pc_d    = in_pc;
            out_first_d = 1'b1;
            out_last_d  = 1'b1;
            cond_d      = in_instr[31:28];
            rn_d        = in_instr[19:16];
            l_d         = in_instr[20];
            u_d         = in_instr[23];
            w_d         = in_instr[21];
            n_d         = in_cnt;
            start_d     = in_start;
            k_d         = CNT_W'(1);
            if (in_is_blk && in_list_nz) begin
              out_instr_d = INSTR_W'(mem_uop(in_instr[31:28], in_instr[20], 1'b0,
                                             in_instr[19:16], 4'(lowest(in_list)),
                                             in_start));
              out_last_d  = (in_rem == '0) & ~in_instr[21];
              mask_d      = in_rem;
`ifdef ID_SWAP_UOP_EN
            end else if (in_is_swp) begin
              out_instr_d = INSTR_W'(mem_uop(in_instr[31:28], 1'b1, in_instr[22],
                                             in_instr[19:16], in_instr[15:12],
                                             OFF_W'(0)));
              out_last_d  = 1'b0;
              rm_d        = in_instr[3:0];
              b_d         = in_instr[22];
`endif
            end else if (in_is_blk) begin
              out_instr_d = INSTR_W'(NOP_UOP);
            end else begin
              out_instr_d = in_instr;
            end
          end
        end
        ST_SEQ: begin
          out_valid_d = 1'b1;
          out_first_d = 1'b0;
          out_last_d  = (seq_rem == '0) & ~w_q;
          out_instr_d = INSTR_W'(mem_uop(cond_q, l_q, 1'b0, rn_q, 4'(lowest(mask_q)),
                                         start_q + OFF_W'({k_q, 2'b00})));
          mask_d      = seq_rem;
          k_d         = k_q + CNT_W'(1);
        end
        ST_WB: begin
          out_valid_d = 1'b1;
          out_first_d = 1'b0;
          out_last_d  = 1'b1;
          out_instr_d = INSTR_W'(wb_uop(cond_q, u_q, rn_q, n_q));
        end
`ifdef ID_SWAP_UOP_EN
        ST_SWP2: begin
          out_valid_d = 1'b1;
          out_first_d = 1'b0;
          out_last_d  = 1'b1;
          out_instr_d = INSTR_W'(mem_uop(cond_q, 1'b0, b_q, rn_q, rm_q, OFF_W'(0)));
        end
`endif
        default: out_valid_d = 1'b0;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q      <= '0;
      k_q         <= '0;
      n_q         <= '0;
      start_q     <= '0;
      cond_q      <= '0;
      rn_q        <= '0;
      l_q         <= 1'b0;
      u_q         <= 1'b0;
      w_q         <= 1'b0;
`ifdef ID_SWAP_UOP_EN
      rm_q        <= '0;
      b_q         <= 1'b0;
`endif
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      k_q         <= k_d;
      n_q         <= n_d;
      start_q     <= start_d;
      cond_q      <= cond_d;
      rn_q        <= rn_d;
      l_q         <= l_d;
      u_q         <= u_d;
      w_q         <= w_d;
`ifdef ID_SWAP_UOP_EN
      rm_q        <= rm_d;
      b_q         <= b_d;
`endif
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule
